// File: rtl/apb_master_fsm.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_fsm
// Purpose  : Destination-side APB master of the asynchronous bridge. It takes
//            one command at a time from the CDC command FIFO read port, runs
//            the APB SETUP/ACCESS sequence toward the slave decoder/mux, and
//            returns read data and status to the CDC response FIFO write port.
//            The address passes through unmodified. The decoder selects the
//            slave from b_paddr[ADDR_WD-1:ADDR_WD-2].
//
// Ports    : b_pclk, b_prst_n        clock, asynchronous active-low reset
//            cmd_*                   command FIFO read side (valid/ready)
//            rsp_*                   response FIFO write side (valid/ready)
//            b_psel .. b_pstrb       APB request outputs (all registered)
//            b_prdata, b_pready      APB completion inputs from the mux
//
// Options  : APB_TIMEOUT_EN - when defined, ACCESS is abandoned after
//            TIMEOUT_CYC cycles with b_pready low, and the response is
//            returned with rsp_err=1. When undefined, ACCESS waits
//            indefinitely and rsp_err is always 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_fsm #(
    parameter int ADDR_WD     = 32,
    parameter int DATA_WD     = 32,
    parameter int STRB_WD     = 4,
    parameter int PROT_WD     = 3,
    parameter int TIMEOUT_CYC = 255,
    parameter int TIMEOUT_WD  = 8
) (
    input  logic               b_pclk,
    input  logic               b_prst_n,
    // command FIFO read side
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [DATA_WD-1:0] cmd_wdata,
    input  logic [STRB_WD-1:0] cmd_strb,
    input  logic [PROT_WD-1:0] cmd_prot,
    // response FIFO write side
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic               rsp_write,
    output logic               rsp_err,
    // APB master
    output logic               b_psel,
    output logic               b_penable,
    output logic               b_pwrite,
    output logic [ADDR_WD-1:0] b_paddr,
    output logic [DATA_WD-1:0] b_pwdata,
    output logic [PROT_WD-1:0] b_pprot,
    output logic [STRB_WD-1:0] b_pstrb,
    input  logic [DATA_WD-1:0] b_prdata,
    input  logic               b_pready
);

    // Elaboration-time sanity check on the timeout configuration.
    generate
        if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255) ||
            ((TIMEOUT_CYC - 1) >= (1 << TIMEOUT_WD))) begin : g_tmo_chk
            $error("apb_master_fsm: TIMEOUT_CYC must be 1..255 and fit in TIMEOUT_WD bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               w_psel_nxt;
    logic               w_penable_nxt;
    logic               w_pwrite_nxt;
    logic [ADDR_WD-1:0] w_paddr_nxt;
    logic [DATA_WD-1:0] w_pwdata_nxt;
    logic [PROT_WD-1:0] w_pprot_nxt;
    logic [STRB_WD-1:0] w_pstrb_nxt;
    logic               w_rsp_valid_nxt;
    logic [DATA_WD-1:0] w_rsp_rdata_nxt;
    logic               w_rsp_write_nxt;
    logic               w_rsp_err_nxt;

`ifdef APB_TIMEOUT_EN
    localparam logic [TIMEOUT_WD-1:0] c_tmo_last = TIMEOUT_WD'(TIMEOUT_CYC - 1);
    logic [TIMEOUT_WD-1:0] r_tmo_cnt;
    logic [TIMEOUT_WD-1:0] w_tmo_cnt_nxt;
`endif

    // Only the command handshake is combinational; everything else is a flop.
    assign cmd_ready = (r_state == IDLE);

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every register holds by default,
    // so the APB request fields keep their last values between transfers
    // and rsp_rdata holds until the next capture.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = b_psel;
        w_penable_nxt   = b_penable;
        w_pwrite_nxt    = b_pwrite;
        w_paddr_nxt     = b_paddr;
        w_pwdata_nxt    = b_pwdata;
        w_pprot_nxt     = b_pprot;
        w_pstrb_nxt     = b_pstrb;
        w_rsp_valid_nxt = rsp_valid;
        w_rsp_rdata_nxt = rsp_rdata;
        w_rsp_write_nxt = rsp_write;
        w_rsp_err_nxt   = rsp_err;
`ifdef APB_TIMEOUT_EN
        w_tmo_cnt_nxt   = r_tmo_cnt;
`endif

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_pwrite_nxt  = cmd_write;
                    w_paddr_nxt   = cmd_addr;
                    w_pwdata_nxt  = cmd_wdata;
                    w_pprot_nxt   = cmd_prot;
                    // Reads never present strobes on the bus.
                    w_pstrb_nxt   = cmd_write ? cmd_strb : '0;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = SETUP;
                end
            end

            SETUP: begin
                w_penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
                w_tmo_cnt_nxt = '0;
`endif
                w_state_nxt   = ACCESS;
            end

            ACCESS: begin
                // A ready slave wins over a timeout that expires on the same cycle.
                if (b_pready) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_rdata_nxt = b_pwrite ? '0 : b_prdata;
                    w_rsp_write_nxt = b_pwrite;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (r_tmo_cnt == c_tmo_last) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_write_nxt = b_pwrite;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
`endif
            end

            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. The asynchronous reset drops psel,
    // penable and rsp_valid immediately and discards any in-flight
    // transfer.
    // ------------------------------------------------------------------
    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            r_state   <= IDLE;
            b_psel    <= 1'b0;
            b_penable <= 1'b0;
            b_pwrite  <= 1'b0;
            b_paddr   <= '0;
            b_pwdata  <= '0;
            b_pprot   <= '0;
            b_pstrb   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            b_psel    <= w_psel_nxt;
            b_penable <= w_penable_nxt;
            b_pwrite  <= w_pwrite_nxt;
            b_paddr   <= w_paddr_nxt;
            b_pwdata  <= w_pwdata_nxt;
            b_pprot   <= w_pprot_nxt;
            b_pstrb   <= w_pstrb_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_rdata <= w_rsp_rdata_nxt;
            rsp_write <= w_rsp_write_nxt;
            rsp_err   <= w_rsp_err_nxt;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end
`endif

endmodule
`default_nettype wire
